// File: rtl/button_step_pulse.sv
// Push-button front end: synchronizer, debounce FSM, auto-repeat.
// Emits one registered step pulse per accepted press or repeat.
module button_step_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CW              = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       step,
  output logic       btn_level,
  output logic       held,
  output logic [7:0] step_count
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    REPEAT,
    DB_RELEASE
  } state_t;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);

  state_t        state;
  state_t        state_nx;
  logic          sync1;
  logic          s;
  logic [CW-1:0] timer;
  logic [CW-1:0] timer_nx;
  logic          step_nx;
  logic          level_nx;
  logic          held_nx;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn_in;
      s     <= sync1;
    end
  end

  // next state, timer and pulse; release always wins over a step
  always_comb begin
    state_nx = state;
    timer_nx = timer + CW'(1);
    step_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) state_nx = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s) begin
          state_nx = IDLE;
        end else if (timer == DB_LAST) begin
          state_nx = PRESSED;
          step_nx  = 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nx = DB_RELEASE;
        end else if (timer == HLD_LAST) begin
          if (repeat_en) begin
            state_nx = REPEAT;
            step_nx  = 1'b1;
          end else begin
            timer_nx = timer;
          end
        end
      end
      REPEAT: begin
        if (!s) begin
          state_nx = DB_RELEASE;
        end else if (!repeat_en) begin
          state_nx = PRESSED;
        end else if (timer == REP_LAST) begin
          step_nx  = 1'b1;
          timer_nx = '0;
        end
      end
      DB_RELEASE: begin
        if (s) begin
          state_nx = PRESSED;
        end else if (timer == DB_LAST) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (state_nx != state) timer_nx = '0;
    level_nx = (state_nx == PRESSED) ||
               (state_nx == REPEAT) ||
               (state_nx == DB_RELEASE);
    held_nx  = (state_nx == REPEAT);
  end

  // state, timer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      step       <= 1'b0;
      btn_level  <= 1'b0;
      held       <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      step       <= step_nx;
      btn_level  <= level_nx;
      held       <= held_nx;
      step_count <= step_count + 8'(step);
    end
  end

endmodule

// File: tb/tb_button_step_pulse.sv
// Directed bench for button_step_pulse at default parameters.
// Edge k means the k-th rising edge after the stimulus change.
module tb_button_step_pulse;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       repeat_en;
  logic       step;
  logic       btn_level;
  logic       held;
  logic [7:0] step_count;

  int total;
  int bad;

  button_step_pulse dut (
    .clk       (clk),
    .reset     (rst_n),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .step      (step),
    .btn_level (btn_level),
    .held      (held),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0h want=%0h",
             tag, k, obs, exp);
    end
  endtask

  task automatic press(input int hi, input int lo);
    btn_in = 1'b1;
    repeat (hi) tick();
    btn_in = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    btn_in    = 1'b0;
    repeat_en = 1'b0;

    // reset held while button toggles
    for (int i = 0; i < 5; i++) begin
      btn_in = i[0];
      tick();
      chk("rst_step", i, 8'(step), 8'd0);
      chk("rst_lvl", i, 8'(btn_level), 8'd0);
      chk("rst_held", i, 8'(held), 8'd0);
      chk("rst_cnt", i, step_count, 8'd0);
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_step", i, 8'(step), 8'd0);
      chk("idle_lvl", i, 8'(btn_level), 8'd0);
    end

    // clean press, no repeat
    btn_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("cp_step", k, 8'(step), 8'(k == 7));
      chk("cp_lvl", k, 8'(btn_level),
          8'(k >= 7 && k < 37));
      chk("cp_held", k, 8'(held), 8'd0);
      if (k == 30) btn_in = 1'b0;
    end
    chk("cp_cnt", 0, step_count, 8'd1);

    // short glitch is rejected
    btn_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("gl_step", k, 8'(step), 8'd0);
      chk("gl_lvl", k, 8'(btn_level), 8'd0);
      if (k == 3) btn_in = 1'b0;
    end
    chk("gl_cnt", 0, step_count, 8'd1);

    // release bounce while held
    btn_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("rb_step", k, 8'(step), 8'(k == 7));
      chk("rb_lvl", k, 8'(btn_level),
          8'(k >= 7 && k < 37));
      if (k == 15) btn_in = 1'b0;
      if (k == 17) btn_in = 1'b1;
      if (k == 30) btn_in = 1'b0;
    end
    chk("rb_cnt", 0, step_count, 8'd2);

    // auto-repeat for a 50-cycle hold
    repeat_en = 1'b1;
    btn_in    = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk("ar_step", k, 8'(step),
          8'(k == 7 || k == 23 || k == 31 ||
             k == 39 || k == 47));
      chk("ar_held", k, 8'(held),
          8'(k >= 23 && k < 53));
      chk("ar_lvl", k, 8'(btn_level),
          8'(k >= 7 && k < 57));
      if (k == 50) btn_in = 1'b0;
    end
    chk("ar_cnt", 0, step_count, 8'd7);

    // repeat_en dropped at edge 35
    btn_in = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk("rd_step", k, 8'(step),
          8'(k == 7 || k == 23 || k == 31));
      chk("rd_held", k, 8'(held),
          8'(k >= 23 && k < 35));
      if (k == 34) repeat_en = 1'b0;
      if (k == 50) btn_in = 1'b0;
    end
    chk("rd_cnt", 0, step_count, 8'd10);

    // count wraps through 255 to 0
    for (int i = 0; i < 245; i++) press(10, 10);
    chk("wr_255", 0, step_count, 8'd255);
    press(10, 10);
    chk("wr_0", 0, step_count, 8'd0);

    // async reset in the middle of REPEAT
    repeat_en = 1'b1;
    btn_in    = 1'b1;
    repeat (30) tick();
    chk("ar2_held", 0, 8'(held), 8'd1);
    chk("ar2_cnt", 0, step_count, 8'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("as_held", 0, 8'(held), 8'd0);
    chk("as_lvl", 0, 8'(btn_level), 8'd0);
    chk("as_cnt", 0, step_count, 8'd0);
    chk("as_step", 0, 8'(step), 8'd0);
    rst_n = 1'b1;

    // held button is re-debounced as a new press
    repeat_en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("rp_step", k, 8'(step), 8'(k == 7));
      chk("rp_lvl", k, 8'(btn_level), 8'(k >= 7));
    end
    chk("rp_cnt", 0, step_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
